// File: rtl/jtkcpu_memseq_if.sv
// Request/response and external 8-bit bus bundle for the kcpu bus sequencer.
// slave is the sequencer side; master is the control unit plus bus target.
interface jtkcpu_memseq_if #(
  parameter int AW = 16
);
  logic          req_fetch;
  logic          req_rd;
  logic          req_wr;
  logic          req_wide;
  logic [AW-1:0] req_addr;
  logic [15:0]   req_wdata;
  logic [7:0]    op;
  logic [15:0]   mdata;
  logic          mem_busy;
  logic          bus_err;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_dout;
  logic [7:0]    bus_din;
  logic          bus_cs;
  logic          bus_we;
  logic          bus_ok;

  modport slave (
    input  req_fetch, req_rd, req_wr, req_wide,
    input  req_addr, req_wdata,
    output op, mdata, mem_busy, bus_err,
    output bus_addr, bus_dout, bus_cs, bus_we,
    input  bus_din, bus_ok
  );

  modport master (
    output req_fetch, req_rd, req_wr, req_wide,
    output req_addr, req_wdata,
    input  op, mdata, mem_busy, bus_err,
    input  bus_addr, bus_dout, bus_cs, bus_we,
    output bus_din, bus_ok
  );
endinterface

// File: rtl/jtkcpu_memseq.sv
// kcpu bus sequencer: splits fetch/read/write requests into 8-bit
// bus cycles with wait states and big-endian 16-bit assembly.
module jtkcpu_memseq #(
  parameter int AW      = 16,
  parameter bit BUSWAIT = 1'b1
) (
  input logic            clk,
  input logic            rst,
  input logic            cen,
  jtkcpu_memseq_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    B0,
    B1,
    DONE
  } state_t;

  state_t     r_state;
  logic       r_wide;
  logic       r_wr;
  logic       r_fetch;
  logic [7:0] r_lo;
  logic [7:0] r_hi;

  logic w_any;
  logic w_multi;
  logic w_fetch;
  logic w_wide;
  logic w_ok;

  assign w_any   = bus.req_fetch | bus.req_rd | bus.req_wr;
  assign w_multi = (bus.req_wr & (bus.req_fetch | bus.req_rd))
                 | (bus.req_fetch & bus.req_rd);
  // write beats fetch, and a fetch is never wide
  assign w_fetch = ~bus.req_wr & bus.req_fetch;
  assign w_wide  = bus.req_wide & ~w_fetch;
  assign w_ok    = (BUSWAIT == 1'b0) | bus.bus_ok;

  assign bus.mem_busy = (r_state != IDLE) | w_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wide       <= 1'b0;
      r_wr         <= 1'b0;
      r_fetch      <= 1'b0;
      r_lo         <= 8'h00;
      r_hi         <= 8'h00;
      bus.op       <= 8'h00;
      bus.mdata    <= 16'h0000;
      bus.bus_err  <= 1'b0;
      bus.bus_addr <= '0;
      bus.bus_dout <= 8'h00;
      bus.bus_cs   <= 1'b0;
      bus.bus_we   <= 1'b0;
    end else if (cen) begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state      <= B0;
            r_wr         <= bus.req_wr;
            r_fetch      <= w_fetch;
            r_wide       <= w_wide;
            r_lo         <= bus.req_wdata[7:0];
            bus.bus_cs   <= 1'b1;
            bus.bus_we   <= bus.req_wr;
            bus.bus_addr <= bus.req_addr;
            bus.bus_dout <= w_wide ? bus.req_wdata[15:8]
                                   : bus.req_wdata[7:0];
            if (w_multi) bus.bus_err <= 1'b1;
          end
        end
        B0: begin
          if (w_ok) begin
            if (r_wide) begin
              r_state      <= B1;
              r_hi         <= bus.bus_din;
              bus.bus_addr <= bus.bus_addr + AW'(1);
              bus.bus_dout <= r_lo;
            end else begin
              r_state    <= DONE;
              bus.bus_cs <= 1'b0;
              bus.bus_we <= 1'b0;
              if (r_fetch)    bus.op    <= bus.bus_din;
              else if (!r_wr) bus.mdata <= {8'h00, bus.bus_din};
            end
          end
        end
        B1: begin
          // high byte waits in r_hi so mdata never shows half a word
          if (w_ok) begin
            r_state    <= DONE;
            bus.bus_cs <= 1'b0;
            bus.bus_we <= 1'b0;
            if (!r_wr) bus.mdata <= {r_hi, bus.bus_din};
          end
        end
        DONE: r_state <= IDLE;
      endcase
      if ((r_state != IDLE) && w_any) bus.bus_err <= 1'b1;
    end
  end
endmodule
